// File: rtl/mem_stage.sv
// mem_stage: memory stage of the pipelined 64-bit CPU.
// It takes the EX/MEM pipeline register outputs and performs the data-memory
// access over a req/ack handshake. While the memory is busy it stalls the
// upstream stages. An access that waits too long without an ack is aborted.
// The stage registers the MEM/WB outputs that writeback consumes.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   ex_*                EX/MEM inputs (address/ALU result, store data, rd,
//                       control bits, instruction word)
//   dmem_req/we/addr/   data-memory request side (combinational)
//   dmem_wdata
//   dmem_rdata/ack      data-memory response side
//   mem_stall           upstream hold request (combinational)
//   wb_*                registered MEM/WB outputs
//   mem_fault           sticky wait-limit timeout flag, cleared only by rst
module mem_stage #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] ex_alu_result,
    input  logic [63:0] ex_db,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_wr,
    input  logic        ex_reg_wr,
    input  logic        ex_mem_to_reg,
    input  logic [31:0] ex_instruction,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [63:0] dmem_addr,
    output logic [63:0] dmem_wdata,
    input  logic [63:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic [63:0] wb_result,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_wr,
    output logic [31:0] wb_instruction,
    output logic        mem_fault
);

    localparam int CNT_W = $clog2(WAIT_LIMIT + 1);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(WAIT_LIMIT);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic [CNT_W-1:0] wait_cnt_nxt_s;

    logic access_s;
    logic load_s;
    logic timeout_s;

    // A store wins when both store and load are flagged.
    assign access_s  = ex_mem_wr | ex_mem_to_reg;
    assign load_s    = ex_mem_to_reg & ~ex_mem_wr;
    assign timeout_s = access_s & ~dmem_ack & (wait_cnt_r == LIMIT_C);

    assign dmem_req   = access_s & ~rst;
    assign dmem_we    = ex_mem_wr;
    assign dmem_addr  = ex_alu_result;
    assign dmem_wdata = ex_db;
    // The timeout cycle itself is not a stall: the bubble retires and the
    // pipeline moves on.
    assign mem_stall  = access_s & ~dmem_ack & ~timeout_s & ~rst;

    // Next-state and wait-counter logic of the handshake FSM.
    always_comb begin
        next_state_s   = state_r;
        wait_cnt_nxt_s = {CNT_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (access_s & ~dmem_ack & ~timeout_s) begin
                    next_state_s   = ST_WAIT;
                    wait_cnt_nxt_s = wait_cnt_r + CNT_W'(1);
                end else begin
                    next_state_s   = ST_IDLE;
                    wait_cnt_nxt_s = {CNT_W{1'b0}};
                end
            end
            ST_WAIT: begin
                // Leaving on an ack, a timeout or a vanished access all return the
                // counter to zero.
                if (dmem_ack | timeout_s | ~access_s) begin
                    next_state_s   = ST_IDLE;
                    wait_cnt_nxt_s = {CNT_W{1'b0}};
                end else begin
                    next_state_s   = ST_WAIT;
                    wait_cnt_nxt_s = wait_cnt_r + CNT_W'(1);
                end
            end
            default: begin
                next_state_s   = ST_IDLE;
                wait_cnt_nxt_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // FSM state and wait-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            wait_cnt_r <= {CNT_W{1'b0}};
        end else begin
            state_r    <= next_state_s;
            wait_cnt_r <= wait_cnt_nxt_s;
        end
    end

    // MEM/WB pipeline register and the sticky fault flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            wb_result      <= 64'd0;
            wb_rd          <= 5'd0;
            wb_reg_wr      <= 1'b0;
            wb_instruction <= 32'd0;
            mem_fault      <= 1'b0;
        end else if (timeout_s) begin
            wb_result      <= 64'd0;
            wb_rd          <= 5'd0;
            wb_reg_wr      <= 1'b0;
            wb_instruction <= 32'd0;
            mem_fault      <= 1'b1;
        end else if (mem_stall) begin
            wb_result      <= 64'd0;
            wb_rd          <= 5'd0;
            wb_reg_wr      <= 1'b0;
            wb_instruction <= 32'd0;
            mem_fault      <= mem_fault;
        end else begin
            // The only cases left are a non-access and an acked access.
            wb_result      <= (load_s & dmem_ack) ? dmem_rdata : ex_alu_result;
            wb_rd          <= ex_rd;
            wb_reg_wr      <= ex_reg_wr;
            wb_instruction <= ex_instruction;
            mem_fault      <= mem_fault;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    localparam int LIM = 4;

    logic        clk;
    logic        rst;
    logic [63:0] ex_alu_result;
    logic [63:0] ex_db;
    logic [4:0]  ex_rd;
    logic        ex_mem_wr;
    logic        ex_reg_wr;
    logic        ex_mem_to_reg;
    logic [31:0] ex_instruction;
    logic        dmem_req;
    logic        dmem_we;
    logic [63:0] dmem_addr;
    logic [63:0] dmem_wdata;
    logic [63:0] dmem_rdata;
    logic        dmem_ack;
    logic        mem_stall;
    logic [63:0] wb_result;
    logic [4:0]  wb_rd;
    logic        wb_reg_wr;
    logic [31:0] wb_instruction;
    logic        mem_fault;

    int   errors = 0;
    int   checks = 0;
    logic fault_model = 1'b0;

    mem_stage #(.WAIT_LIMIT(LIM)) dut (
        .clk(clk), .rst(rst),
        .ex_alu_result(ex_alu_result), .ex_db(ex_db), .ex_rd(ex_rd),
        .ex_mem_wr(ex_mem_wr), .ex_reg_wr(ex_reg_wr),
        .ex_mem_to_reg(ex_mem_to_reg), .ex_instruction(ex_instruction),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .mem_stall(mem_stall),
        .wb_result(wb_result), .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr),
        .wb_instruction(wb_instruction), .mem_fault(mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_wb(input string tag, input logic [63:0] res, input logic [4:0] rd,
                          input logic rw, input logic [31:0] ins);
        chk({tag, ".wb_result"}, wb_result, res);
        chk({tag, ".wb_rd"}, 64'(wb_rd), 64'(rd));
        chk({tag, ".wb_reg_wr"}, 64'(wb_reg_wr), 64'(rw));
        chk({tag, ".wb_instruction"}, 64'(wb_instruction), 64'(ins));
        chk({tag, ".mem_fault"}, 64'(mem_fault), 64'(fault_model));
    endtask

    // Transaction-level model: kind 0=ALU, 1=load, 2=store, 3=store with load bit.
    // k = number of cycles the memory waits before acking (k > LIM: never).
    task automatic run_instr(input int kind, input logic [63:0] alu, input logic [63:0] db,
                             input logic [4:0] rd, input logic rw, input logic [31:0] ins,
                             input logic [63:0] rdata, input int k);
        logic access;
        logic ack_now;
        logic done;
        ex_alu_result  = alu;
        ex_db          = db;
        ex_rd          = rd;
        ex_reg_wr      = rw;
        ex_instruction = ins;
        ex_mem_wr      = (kind >= 2);
        ex_mem_to_reg  = (kind == 1) || (kind == 3);
        access         = (kind != 0);
        done           = 1'b0;
        for (int c = 0; c <= LIM && !done; c++) begin
            ack_now    = access ? (c == k) : 1'($urandom_range(0, 1));
            dmem_ack   = ack_now;
            dmem_rdata = ack_now ? rdata : {$urandom, $urandom};
            @(negedge clk);
            chk("dmem_req", 64'(dmem_req), 64'(access));
            if (access) begin
                chk("dmem_we", 64'(dmem_we), 64'(kind >= 2));
                chk("dmem_addr", dmem_addr, alu);
                chk("dmem_wdata", dmem_wdata, db);
            end
            chk("mem_stall", 64'(mem_stall), 64'(access && !ack_now && c < LIM));
            @(posedge clk);
            #1;
            if (!access || ack_now) begin
                chk_wb("retire", (kind == 1) ? rdata : alu, rd, rw, ins);
                done = 1'b1;
            end else if (c == LIM) begin
                fault_model = 1'b1;
                chk_wb("timeout", 64'd0, 5'd0, 1'b0, 32'd0);
                done = 1'b1;
            end else begin
                chk_wb("bubble", 64'd0, 5'd0, 1'b0, 32'd0);
            end
        end
        dmem_ack = 1'b0;
    endtask

    initial begin
        // Reset held two cycles with a load presented.
        rst = 1'b1;
        fault_model = 1'b0;
        ex_alu_result = 64'h40; ex_db = 64'd0; ex_rd = 5'd3; ex_reg_wr = 1'b1;
        ex_mem_wr = 1'b0; ex_mem_to_reg = 1'b1; ex_instruction = 32'h00003003;
        dmem_ack = 1'b0; dmem_rdata = 64'd0;
        repeat (2) begin
            @(negedge clk);
            chk("rst.dmem_req", 64'(dmem_req), 64'd0);
            chk("rst.mem_stall", 64'(mem_stall), 64'd0);
            @(posedge clk);
            #1;
            chk_wb("rst", 64'd0, 5'd0, 1'b0, 32'd0);
        end
        rst = 1'b0;

        // Directed steps.
        run_instr(0, 64'h1234, 64'd0, 5'd5, 1'b1, 32'h00500093, 64'd0, 0);
        run_instr(1, 64'h40, 64'd0, 5'd7, 1'b1, 32'h04003383, 64'hDEADBEEF, 3);
        run_instr(2, 64'h80, 64'h55, 5'd0, 1'b0, 32'h08503023, 64'd0, 0);
        run_instr(1, 64'h100, 64'd0, 5'd9, 1'b1, 32'h10003483, 64'h1111, LIM + 1);
        run_instr(0, 64'hABCD, 64'd0, 5'd10, 1'b1, 32'h00A00513, 64'd0, 0);
        run_instr(1, 64'h200, 64'd0, 5'd11, 1'b1, 32'h20003583, 64'hAAAA_0001, 1);
        run_instr(1, 64'h208, 64'd0, 5'd12, 1'b1, 32'h20803603, 64'hBBBB_0002, 1);

        // Load left waiting, then reset in the middle of the wait.
        ex_alu_result = 64'h300; ex_rd = 5'd13; ex_reg_wr = 1'b1;
        ex_mem_wr = 1'b0; ex_mem_to_reg = 1'b1; ex_instruction = 32'h30003683;
        dmem_ack = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("midwait.mem_stall", 64'(mem_stall), 64'd1);
            @(posedge clk);
            #1;
            chk_wb("midwait.bubble", 64'd0, 5'd0, 1'b0, 32'd0);
        end
        rst = 1'b1;
        dmem_rdata = 64'h5555_5555;
        dmem_ack = 1'b1;
        @(negedge clk);
        chk("midrst.dmem_req", 64'(dmem_req), 64'd0);
        chk("midrst.mem_stall", 64'(mem_stall), 64'd0);
        @(posedge clk);
        #1;
        fault_model = 1'b0;
        chk_wb("midrst", 64'd0, 5'd0, 1'b0, 32'd0);
        chk("midrst.wait_cnt", 64'(dut.wait_cnt_r), 64'd0);
        rst = 1'b0;
        dmem_ack = 1'b0;

        // An ack exactly at the wait limit completes normally, with no fault.
        run_instr(1, 64'h400, 64'd0, 5'd14, 1'b1, 32'h40003703, 64'hCAFE_F00D, LIM);

        // Randomised instruction stream.
        for (int n = 0; n < 60; n++) begin
            run_instr($urandom_range(0, 3), {$urandom, $urandom}, {$urandom, $urandom},
                      5'($urandom), 1'($urandom), $urandom, {$urandom, $urandom},
                      $urandom_range(0, LIM + 1));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the pipelined 64-bit CPU. It consumes the EX/MEM pipeline register outputs, performs the data-memory access over a req/ack handshake, and stalls upstream stages while memory is busy. It also aborts accesses that exceed a wait limit, and registers the MEM/WB pipeline outputs consumed by writeback.

## Interface
Parameters:
- WAIT_LIMIT, 15, maximum wait cycles without ack before abort (≥1)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- ex_alu_result  in  64  ALU result / memory address
- ex_db  in  64  store data
- ex_rd  in  5  destination register
- ex_mem_wr  in  1  store
- ex_reg_wr  in  1  register write enable
- ex_mem_to_reg  in  1  load (writeback selects memory data)
- ex_instruction  in  32  instruction word
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  64  = ex_alu_result
- dmem_wdata  out  64  = ex_db
- dmem_rdata  in  64  read data, valid when dmem_ack=1
- dmem_ack  in  1  access complete this cycle
- mem_stall  out  1  upstream holds all ex_* stable while 1
- wb_result  out  64  registered writeback value
- wb_rd  out  5  registered destination
- wb_reg_wr  out  1  registered write enable
- wb_instruction  out  32  registered instruction
- mem_fault  out  1  sticky timeout flag

## Operation
- access = ex_mem_wr | ex_mem_to_reg; store = ex_mem_wr (priority if both set); load = ex_mem_to_reg & ~ex_mem_wr.
- dmem_req = access & ~rst (combinational); dmem_we = store; addr/wdata driven combinationally from ex_* at all times.
- wait_cnt: width $clog2(WAIT_LIMIT+1). Increments each edge with dmem_req=1 and dmem_ack=0. Clears on ack, on timeout, when no access, and on rst.
- timeout = access & ~dmem_ack & (wait_cnt == WAIT_LIMIT).
- mem_stall = access & ~dmem_ack & ~timeout & ~rst (combinational).
- State: IDLE (wait_cnt=0) / WAIT (wait_cnt>0). IDLE→WAIT on req without ack. WAIT→IDLE on ack or timeout.
- MEM/WB update every edge:
  - Non-access: wb_result=ex_alu_result, wb_rd=ex_rd, wb_reg_wr=ex_reg_wr, wb_instruction=ex_instruction.
  - Access with ack: same as non-access, except load sets wb_result=dmem_rdata.
  - Stall cycle (mem_stall=1): load a bubble (all wb_* = 0).
  - Timeout: load a bubble and set mem_fault.
- mem_fault stays 1 until rst. The pipeline continues normally after a fault.
- dmem_ack while dmem_req=0 is ignored.

## Timing
- Reset values: wb_result=0, wb_rd=0, wb_reg_wr=0, wb_instruction=0, mem_fault=0, wait_cnt=0. dmem_req=0 and mem_stall=0 while rst=1.
- Non-access and same-cycle-ack accesses: zero stall, 1-cycle latency ex_*→wb_*.
- Ack after k cycles of req (k ≤ WAIT_LIMIT): mem_stall high exactly k cycles, k bubbles into wb_*, result on edge k+1.
- Ack never arrives: req held WAIT_LIMIT+1 cycles; mem_stall high WAIT_LIMIT cycles, low in the final cycle; mem_fault=1 after that edge.
- Ack in the cycle wait_cnt==WAIT_LIMIT: normal completion, no fault.
- Back-to-back accesses: the next instruction's req is asserted in the cycle immediately after the ack edge, with no idle cycle.
- Reset mid-WAIT: at the reset edge, wait_cnt=0, wb_* cleared, mem_fault cleared; no completion is recorded.

## Test plan
- Reset: hold rst 2 cycles with load presented → dmem_req=0, mem_stall=0, all wb_*=0, mem_fault=0.
- ALU op: ex_reg_wr=1, ex_rd=5, ex_alu_result=0x1234, no mem → dmem_req=0, mem_stall=0; next edge wb_result=0x1234, wb_rd=5, wb_reg_wr=1.
- Load, ack after 3 wait cycles with dmem_rdata=0xDEADBEEF, ex_rd=7, addr 0x40 → dmem_addr=0x40, dmem_we=0, mem_stall high 3 cycles with wb_reg_wr=0; then wb_result=0xDEADBEEF, wb_rd=7, wb_reg_wr=1.
- Store with same-cycle ack, ex_alu_result=0x80, ex_db=0x55 → dmem_we=1, dmem_addr=0x80, dmem_wdata=0x55, mem_stall=0; wb_reg_wr=0 next edge.
- WAIT_LIMIT=4, load, ack never → dmem_req high 5 cycles, mem_stall high 4, mem_fault=1 after 5th edge, wb_reg_wr=0; the following ALU op retires normally; mem_fault remains 1 until rst.
- Back-to-back loads (ack after 1 cycle each), then a load with rst asserted mid-WAIT → two correct results in order with one bubble each; on rst, wait_cnt=0 and wb_*=0, with no stale write.
